bin2dec_seq_ctrl: RTL
=====================

// Module: bin2dec_seq_ctrl
// PURPOSE
//  Sequential binary-to-decimal conversion controller for the DE2 seven-segment displays.
//  - Accepts a WIDTH-bit binary value on a start strobe.
//  - Converts it serially by shift-and-add-3 (double-dabble), one bit per clock.
//  - Registers the BCD digits and their active-low 7-seg patterns for HEX0..HEX(DIGITS-1).
//  - Replaces the per-value combinational %/÷ decode path with a bounded, pipelined converter.
// PARAMETERS
//  WIDTH    8  binary input width, >=1
//  DIGITS   3  decimal digits produced, >=1; digit 0 = ones
//  LZ_BLANK 0  1: blank leading-zero digits; digit 0 is never blanked
// PORTS
//  CLOCK_50  in   1           system clock, rising edge
//  rst_n     in   1           asynchronous, active-low reset
//  start     in   1           conversion request; sampled only in IDLE
//  bin_in    in   WIDTH       binary value, captured on the accepted start
//  busy      out  1           high from the cycle after accept through the DONE cycle
//  done      out  1           one-cycle pulse in DONE; outputs valid from that cycle
//  overflow  out  1           value >= 10**DIGITS; held until the next done
//  bcd_out   out  4*DIGITS    packed BCD, digit k at [4k+3:4k]
//  seg_out   out  7*DIGITS    active-low gfedcba, digit k at [7k+6:7k]
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, overflow=0; bcd_out=0.
//   - seg_out = all ones (every digit blank); scratch and counter cleared.
//  FSM states: IDLE, SHIFT, DONE.
//   - IDLE: start=1 -> latch bin_in to shift reg, clear BCD scratch, cnt=WIDTH, ovf=0 -> SHIFT.
//   - SHIFT, per cycle:
//     - add 3 to each scratch digit >=5;
//     - shift {scratch, shreg} left 1;
//     - bit shifted out of the top digit sets sticky ovf;
//     - cnt-1; at cnt==1 -> DONE.
//   - DONE, single cycle:
//     - done=1; bcd_out <= scratch; seg_out <= decoded; overflow <= ovf;
//     - -> IDLE.
//  Latency: start accepted at edge N -> done=1 during cycle N+WIDTH+1.
//   - Next start accepted at the earliest on the edge after DONE.
//  Handshake rules:
//   - start during SHIFT or DONE is ignored (not queued).
//   - bin_in changes after accept have no effect.
//  Output hold: bcd_out, seg_out and overflow change only in DONE; otherwise they hold.
//  Segment decode:
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
//   - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
//   - any other code -> blank (1111111).
//  overflow=1: every seg_out digit blank; bcd_out = low DIGITS digits (mod 10**DIGITS).
//  LZ_BLANK=1: digits above the highest nonzero digit blank; value 0 shows "0" on digit 0.
//  Width rules:
//   - scratch is 4*DIGITS bits; add-3 is per digit, 4-bit, no carry between digits.
//   - cnt is clog2(WIDTH+1) bits.
//  Reset mid-conversion: immediate return to IDLE with reset values; no done pulse.
// TESTING (WIDTH=8, DIGITS=3 unless noted)
//  - start, bin_in=15 at edge 0 -> busy at cycles 1..9; done at cycle 9;
//    bcd_out=12'h015; seg_out={1000000,1111001,0010010}.
//  - bin_in=255 -> bcd_out=12'h255, overflow=0; bin_in=0 -> 12'h000, all three digits 1000000.
//  - DIGITS=2, bin_in=255 -> overflow=1, seg_out all ones, bcd_out=8'h55;
//    then bin_in=42 -> overflow=0, bcd_out=8'h42.
//  - start=1 held continuously with bin_in 7 then 9 -> one conversion per 10 cycles;
//    mid-conversion bin_in change ignored; results 7 then 9.
//  - rst_n low at cycle 4 of a conversion -> busy=0, no done pulse, seg_out all ones;
//    the next start converts correctly.
//  - LZ_BLANK=1, bin_in=7 -> digits 2,1 blank, digit 0=1111000.

Source files
------------

// File: rtl/bin2dec_seq_ctrl_if.sv
// Handshake and display bus between a requester and the sequential
// binary-to-decimal controller.
interface bin2dec_seq_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, bcd_out, seg_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, bcd_out, seg_out
  );
endinterface

// File: rtl/bin2dec_seq_ctrl.sv
// Serial double-dabble converter driving registered BCD digits and
// active-low seven-segment patterns, one input bit per clock.
module bin2dec_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int LZ_BLANK = 0
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  bin2dec_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic [CW-1:0]       cnt;
  logic                ovf;
  logic [4*DIGITS-1:0] bcd_q;
  logic [7*DIGITS-1:0] seg_q;
  logic                overflow_q;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scratch_nxt;
  logic [WIDTH-1:0]    shreg_nxt;
  logic                carry;
  logic                ovf_nxt;
  logic [7*DIGITS-1:0] seg_nxt;
  logic                seen;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // The carry out of the top digit means the value no longer fits in DIGITS;
  // the remaining digits still hold the value modulo 10**DIGITS.
  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ? scratch[4*k +: 4] + 4'd3
                                                  : scratch[4*k +: 4];
    end
    {carry, scratch_nxt, shreg_nxt} = {adj, shreg, 1'b0};
    ovf_nxt = ovf | carry;

    seg_nxt = '0;
    seen    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (scratch_nxt[4*k +: 4] != 4'd0) seen = 1'b1;
      if (ovf_nxt || (LZ_BLANK != 0 && k != 0 && !seen))
        seg_nxt[7*k +: 7] = 7'b1111111;
      else
        seg_nxt[7*k +: 7] = seg7(scratch_nxt[4*k +: 4]);
    end
  end

  // Results are loaded on the last shift edge so they are valid while done is high.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      bcd_q      <= '0;
      seg_q      <= '1;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.bin_in;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            ovf     <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= shreg_nxt;
          scratch <= scratch_nxt;
          ovf     <= ovf_nxt;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_q      <= scratch_nxt;
            seg_q      <= seg_nxt;
            overflow_q <= ovf_nxt;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.overflow = overflow_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.seg_out  = seg_q;
endmodule
